rom_stream_reader: RTL and testbench

Sequencer that sits directly upstream of the team's dual-port synchronous ROM (registered outputs, 1-cycle read latency) and turns a (start address, length) command into a valid/ready data stream. It drives one ROM read port, tracks the in-flight read, and buffers returned words in a 2-entry skid FIFO. Downstream consumers can then apply backpressure without losing data and still get 1 word/cycle throughput.

---
 rtl/rom_skid_fifo.sv | 73 +++++++
 rtl/rom_stream_reader.sv | 132 +++++++++++++
 tb/tb_rom_stream_reader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/rom_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rom_skid_fifo
// Description : Two-entry synchronous FIFO with a registered head word.
//               Push and pop may occur in the same cycle, including when
//               the FIFO is full. A pop on an empty FIFO is ignored. A push
//               on a full FIFO without a pop is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_skid_fifo #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    logic [1:0]    r_count;
    logic          w_pop;
    logic          w_push;

    // Qualify requests: a pop needs a word, and a push needs room or a pop
    // in the same cycle.
    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && ((r_count != 2'd2) || w_pop);

    // Storage update. The head register always holds the oldest word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= din;
                    end else begin
                        r_tail <= din;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Count stays the same. With one word, the new word
                    // becomes the head. With two, the queue shifts.
                    if (r_count == 2'd1) begin
                        r_head <= din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head  = r_head;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/rom_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : rom_stream_reader
// Description : Converts a (start address, length) command into reads on a
//               1-cycle-latency synchronous ROM port. Returned words are
//               presented as a valid/ready stream through a 2-entry skid
//               FIFO. The stream sustains 1 word/cycle under full
//               throughput and tolerates arbitrary backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_stream_reader #(
    parameter int WIDTH   = 8,
    parameter int WIDTHAD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTHAD-1:0] start_addr,
    input  logic [WIDTHAD:0]   start_len,
    output logic               busy,
    output logic               done,
    output logic [WIDTHAD-1:0] rom_addr,
    input  logic [WIDTH-1:0]   rom_q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [WIDTHAD-1:0] r_rom_addr;
    logic [WIDTHAD:0]   r_remaining;
    logic               r_inflight;
    logic               r_inflight_last;

    logic [WIDTH:0]     w_fifo_head;
    logic [1:0]         w_fifo_count;
    logic               w_pop;
    logic               w_credit;
    logic               w_issue;
    logic               w_final_hs;

    assign out_valid  = (w_fifo_count != 2'd0);
    assign out_data   = w_fifo_head[WIDTH-1:0];
    assign out_last   = w_fifo_head[WIDTH] & out_valid;
    assign w_pop      = out_valid & out_ready;
    assign w_final_hs = w_pop & out_last;

    // Credit: FIFO words plus the read in flight must not exceed two. A pop
    // in this cycle frees a slot in time for the word being issued now.
    assign w_credit = (({1'b0, w_fifo_count} + {2'b00, r_inflight}) < 3'd2) || w_pop;
    assign w_issue  = (r_state == RUN) && (r_remaining != '0) && w_credit;

    // Command sequencer. Also tracks the read in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_rom_addr      <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == {{WIDTHAD{1'b0}}, 1'b1});

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (start_len != '0) begin
                            r_rom_addr  <= start_addr;
                            r_remaining <= start_len;
                            r_busy      <= 1'b1;
                            r_state     <= RUN;
                        end else begin
                            // An empty command completes without streaming.
                            r_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_issue) begin
                        r_rom_addr  <= r_rom_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == {{WIDTHAD{1'b0}}, 1'b1}) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // All reads have been issued. Finish on the last handshake.
                    if (w_final_hs && !r_inflight) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    rom_skid_fifo #(
        .DW (WIDTH + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_inflight),
        .din   ({r_inflight_last, rom_q}),
        .pop   (w_pop),
        .head  (w_fifo_head),
        .count (w_fifo_count)
    );

    assign busy     = r_busy;
    assign done     = r_done;
    assign rom_addr = r_rom_addr;

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_stream_reader
// Description : Directed scoreboard bench for rom_stream_reader with a
//               registered ROM model holding ROM[i] = 0x10 + i.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_stream_reader;

    localparam int WIDTH   = 8;
    localparam int WIDTHAD = 4;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         start      = 1'b0;
    logic [3:0]   start_addr = '0;
    logic [4:0]   start_len  = '0;
    logic         busy;
    logic         done;
    logic [3:0]   rom_addr;
    logic [7:0]   rom_q;
    logic         out_valid;
    logic         out_ready  = 1'b0;
    logic [7:0]   out_data;
    logic         out_last;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    int         cyc          = 0;
    int         cmd_cyc      = 0;
    int         last_hs_cyc  = 0;
    logic       first_seen   = 1'b1;
    logic       exp_done     = 1'b0;
    logic       hold_pending = 1'b0;
    logic [7:0] held_data    = '0;
    logic       held_last    = 1'b0;
    logic [5:0] pat          = 6'b101001;
    int         pi           = 0;

    always #5 clk = ~clk;

    // Synchronous ROM model with one cycle of read latency.
    always @(posedge clk) rom_q <= {4'h1, rom_addr};

    rom_stream_reader #(
        .WIDTH   (WIDTH),
        .WIDTHAD (WIDTHAD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .start_len  (start_len),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle. Drive inputs at the falling edge and check outputs.
    // Record any handshake that the next rising edge will complete.
    task automatic tick(input logic st, input logic [3:0] a, input logic [4:0] l, input logic rdy);
        exp_t       e;
        logic [3:0] ad;
        @(negedge clk);
        cyc++;
        start      = st;
        start_addr = a;
        start_len  = l;
        out_ready  = rdy;
        check("done", done, exp_done);
        exp_done = 1'b0;
        if (hold_pending) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, held_data);
            check("hold_last", out_last, held_last);
        end
        if (st && !busy) begin
            cmd_cyc    = cyc;
            first_seen = 1'b0;
            if (l == 5'd0) begin
                exp_done = 1'b1;
            end else begin
                for (int i = 0; i < int'(l); i++) begin
                    ad     = a + i[3:0];
                    e.data = {4'h1, ad};
                    e.last = (i == int'(l) - 1);
                    q.push_back(e);
                end
            end
        end
        if (out_valid) begin
            if (!first_seen) begin
                first_seen = 1'b1;
                check("latency", cyc - cmd_cyc, 3);
            end
            if (q.size() == 0) begin
                check("unexpected_valid", out_valid, 0);
            end else if (rdy) begin
                e = q.pop_front();
                check("data", out_data, e.data);
                check("last", out_last, e.last);
                if (e.last) begin
                    exp_done    = 1'b1;
                    last_hs_cyc = cyc;
                end
            end
        end
        hold_pending = out_valid && !rdy;
        held_data    = out_data;
        held_last    = out_last;
    endtask

    // Run until the scoreboard is empty and the DUT is idle.
    // mode 0 holds ready high. mode 1 cycles the backpressure pattern.
    task automatic drain(input int mode);
        int   n;
        logic r;
        n = 0;
        while ((q.size() != 0 || busy) && n < 100) begin
            r = (mode == 0) ? 1'b1 : pat[pi % 6];
            pi++;
            tick(1'b0, 4'd0, 5'd0, r);
            n++;
        end
        check("drain_bound", (n < 100), 1);
        tick(1'b0, 4'd0, 5'd0, 1'b1);
        check("busy_end", busy, 0);
    endtask

    // The FIFO must never be pushed while full unless it is also popped.
    always @(negedge clk) begin
        if (rst_n && dut.u_fifo.push) begin
            check("fifo_overflow", (dut.u_fifo.count == 2'd2) && !dut.u_fifo.pop, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_rom_addr", rom_addr, 0);

        // Basic stream: 0x13..0x16.
        tick(1'b1, 4'd3, 5'd4, 1'b1);
        drain(0);
        check("basic_cycles", last_hs_cyc - cmd_cyc, 6);

        // Wrap-around: 0x1E, 0x1F, 0x10, 0x11.
        tick(1'b1, 4'd14, 5'd4, 1'b1);
        drain(0);

        // Backpressure: 0x10..0x15 with the ready pattern 1,0,0,1,0,1.
        pi = 0;
        tick(1'b1, 4'd0, 5'd6, 1'b1);
        drain(1);

        // Zero length, then a start that arrives while busy is ignored.
        tick(1'b1, 4'd9, 5'd0, 1'b1);
        drain(0);
        tick(1'b1, 4'd7, 5'd3, 1'b1);
        tick(1'b0, 4'd0, 5'd0, 1'b1);
        tick(1'b1, 4'd0, 5'd5, 1'b1);
        drain(0);

        // Full-depth read with wrap.
        tick(1'b1, 4'd5, 5'd16, 1'b1);
        drain(0);
        check("full_cycles", last_hs_cyc - cmd_cyc, 18);

        // Reset mid-operation after two words have been accepted.
        tick(1'b1, 4'd9, 5'd5, 1'b1);
        n = 0;
        while (q.size() > 3 && n < 50) begin
            tick(1'b0, 4'd0, 5'd0, 1'b1);
            n++;
        end
        check("pre_reset_bound", (n < 50), 1);
        @(negedge clk);
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc += 2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_rom_addr", rom_addr, 0);
        check("mid_rst_done", done, 0);
        q.delete();
        exp_done     = 1'b0;
        hold_pending = 1'b0;
        first_seen   = 1'b1;
        tick(1'b0, 4'd0, 5'd0, 1'b1);
        tick(1'b1, 4'd2, 5'd3, 1'b1);
        drain(0);

        check("queue_empty", q.size(), 0);
        check("final_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
